imem_loader: RTL and testbench

Parametrised instruction memory with a built-in program loader for the single-cycle RISC-V core. After reset it zero-fills its array, then accepts a program as a valid/ready word stream. Once loading completes it serves instruction fetches with one-cycle registered latency and flags misaligned and out-of-range fetch addresses. It replaces the fixed 64-word, hard-coded-program instruction store in the fetch stage.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_array.sv | 46 ++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the loader state encoding, the default NOP word and the index-width helper.
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR,
      LOAD,
      RUN
   } state_e;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port instruction store: synchronous write, registered read.
// Writes and reads share one address; the loader never asks for both at once.
module imem_array
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int IW     = idx_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [IW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Storage has no reset; the loader zero-fills it after every reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[addr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a zero-fill pass, a streaming program loader
// and a one-cycle fetch port that flags misaligned and out-of-range addresses.
module imem_loader
   import imem_pkg::*;
#(
   parameter int                DATA_W = 32,
   parameter int                ADDR_W = 32,
   parameter int                DEPTH  = 64,
   parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_DEFAULT)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_start,
   input  logic                     load_valid,
   input  logic [DATA_W-1:0]        load_data,
   input  logic                     load_last,
   output logic                     load_ready,
   output logic [idx_w(DEPTH):0]    load_count,
   output logic                     busy,
   input  logic                     fetch_req,
   input  logic [ADDR_W-1:0]        fetch_addr,
   output logic [DATA_W-1:0]        instr_out,
   output logic                     instr_valid,
   output logic                     fault_misaligned,
   output logic                     fault_range
);

   localparam int IW = idx_w(DEPTH);
   localparam int CW = IW + 1;

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              vld_q, vld_d;
   logic              mis_q, mis_d;
   logic              rng_q, rng_d;

   logic              mem_we, mem_re;
   logic [IW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   logic              xfer, accept, at_end;
   logic              f_mis, f_rng;
   logic [IW-1:0]     f_idx;

   assign f_idx  = fetch_addr[2 +: IW];
   assign f_mis  = |fetch_addr[1:0];
   // DEPTH is a power of two, so any set bit above the index is out of range.
   assign f_rng  = |fetch_addr[ADDR_W-1:IW+2];
   assign at_end = (ptr_q == IW'(DEPTH - 1));
   assign xfer   = (state_q == LOAD) && load_valid;
   assign accept = (state_q == RUN) && fetch_req && !load_start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         mis_q   <= 1'b0;
         rng_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         mis_q   <= mis_d;
         rng_q   <= rng_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      vld_d   = accept;
      mis_d   = accept && f_mis;
      rng_d   = accept && f_rng;
      unique case (state_q)
         CLEAR: begin
            // Pointer wraps back to 0 as the last word is cleared.
            ptr_d = ptr_q + 1'b1;
            if (at_end) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (xfer) begin
               ptr_d = ptr_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (load_last || at_end) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (load_start) begin
               state_d = LOAD;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      load_ready = (state_q == LOAD);
      busy       = (state_q != RUN);
      mem_we     = (state_q == CLEAR) || xfer;
      mem_wdata  = (state_q == CLEAR) ? '0 : load_data;
      mem_addr   = (state_q == RUN) ? f_idx : ptr_q;
      mem_re     = accept && !f_mis && !f_rng;
      instr_out  = (vld_q && !mis_q && !rng_q) ? mem_rdata : NOP;
   end

   assign load_count       = cnt_q;
   assign instr_valid      = vld_q;
   assign fault_misaligned = mis_q;
   assign fault_range      = rng_q;

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IW     (IW)
   ) u_array (
      .clk    (clk),
      .reset  (reset),
      .we     (mem_we),
      .re     (mem_re),
      .addr   (mem_addr),
      .wdata  (mem_wdata),
      .rdata  (mem_rdata)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with DEPTH=16.
// Fetch expectations go through a scoreboard queue, checked one cycle later.
module tb_imem_loader;

   localparam int DEPTH = 16;
   localparam logic [31:0] NOPW = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        mis;
      logic        rng;
   } fvec_t;

   typedef struct {
      logic [31:0] data;
      logic        valid;
      logic        mis;
      logic        rng;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic [4:0]  load_count;
   logic        busy;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        fault_misaligned;
   logic        fault_range;

   int n_pass = 0;
   int n_total = 0;

   fvec_t vt[$];
   exp_t  sb[$];

   imem_loader #(
      .DATA_W (32),
      .ADDR_W (32),
      .DEPTH  (DEPTH)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .load_start       (load_start),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .load_last        (load_last),
      .load_ready       (load_ready),
      .load_count       (load_count),
      .busy             (busy),
      .fetch_req        (fetch_req),
      .fetch_addr       (fetch_addr),
      .instr_out        (instr_out),
      .instr_valid      (instr_valid),
      .fault_misaligned (fault_misaligned),
      .fault_range      (fault_range)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_clear();
      int n;
      n = 0;
      while (!load_ready && n < 100) begin
         tick();
         n++;
      end
      chk("clear_cycles", n, DEPTH);
   endtask

   task automatic load_seq(input logic [31:0] base, input logic [31:0] step,
                           input int n, input bit rnd, input bit use_last);
      int  i;
      int  guard;
      bit  acc;
      i = 0;
      guard = 0;
      while (i < n && guard < 1000) begin
         load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         load_data  = base + step * i;
         load_last  = use_last && (i == n - 1);
         acc = load_valid && load_ready;
         tick();
         if (acc) i++;
         guard++;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("load_words", i, n);
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("restart_count", 32'(load_count), 0);
      chk("restart_ready", 32'(load_ready), 1);
   endtask

   task automatic run_fetches();
      exp_t e;
      foreach (vt[k]) begin
         fetch_req  = 1'b1;
         fetch_addr = vt[k].addr;
         e.data  = vt[k].data;
         e.valid = 1'b1;
         e.mis   = vt[k].mis;
         e.rng   = vt[k].rng;
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         chk($sformatf("instr@%h", vt[k].addr), instr_out, e.data);
         chk($sformatf("valid@%h", vt[k].addr), 32'(instr_valid), 32'(e.valid));
         chk($sformatf("mis@%h", vt[k].addr), 32'(fault_misaligned), 32'(e.mis));
         chk($sformatf("rng@%h", vt[k].addr), 32'(fault_range), 32'(e.rng));
      end
      fetch_req = 1'b0;
      tick();
      chk("idle_valid", 32'(instr_valid), 0);
      chk("idle_instr", instr_out, NOPW);
      vt.delete();
   endtask

   function automatic fvec_t fv(input logic [31:0] a, input logic [31:0] d,
                                input logic m, input logic r);
      fvec_t v;
      v.addr = a;
      v.data = d;
      v.mis  = m;
      v.rng  = r;
      return v;
   endfunction

   initial begin
      int acc;

      // Reset state
      #12;
      chk("rst_busy", 32'(busy), 1);
      chk("rst_ready", 32'(load_ready), 0);
      chk("rst_count", 32'(load_count), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_instr", instr_out, NOPW);
      chk("rst_flags", {30'd0, fault_misaligned, fault_range}, 0);

      // Clear phase with a fetch that must be dropped
      reset = 1'b0;
      fetch_req = 1'b1;
      fetch_addr = 32'h4;
      wait_clear();
      chk("early_valid", 32'(instr_valid), 0);
      chk("early_instr", instr_out, NOPW);
      fetch_req = 1'b0;

      // Three-word program
      load_data = 32'h0000_0000;
      load_valid = 1'b1;
      tick();
      load_data = 32'h0198_06B3;
      tick();
      load_data = 32'h0094_8663;
      load_last = 1'b1;
      chk("busy_before_last", 32'(busy), 1);
      tick();
      load_valid = 1'b0;
      load_last = 1'b0;
      chk("busy_after_load", 32'(busy), 0);
      chk("count_after_load", 32'(load_count), 3);
      chk("ready_after_load", 32'(load_ready), 0);

      vt.push_back(fv(32'h4, 32'h0198_06B3, 1'b0, 1'b0));
      vt.push_back(fv(32'h8, 32'h0094_8663, 1'b0, 1'b0));
      vt.push_back(fv(32'hC, 32'h0000_0000, 1'b0, 1'b0));
      vt.push_back(fv(32'h0, 32'h0000_0000, 1'b0, 1'b0));
      vt.push_back(fv(32'h6, NOPW, 1'b1, 1'b0));
      vt.push_back(fv(32'h40, NOPW, 1'b0, 1'b1));
      vt.push_back(fv(32'h41, NOPW, 1'b1, 1'b1));
      vt.push_back(fv(32'h3C, 32'h0000_0000, 1'b0, 1'b0));
      vt.push_back(fv(32'hFFFF_FFFC, NOPW, 1'b0, 1'b1));
      run_fetches();

      // Full array: 20 words offered, 16 accepted
      pulse_start();
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         load_valid = 1'b1;
         load_data = 32'hA000_0000 + acc;
         if (load_ready) acc++;
         tick();
      end
      load_valid = 1'b0;
      chk("full_accepted", acc, DEPTH);
      chk("full_ready", 32'(load_ready), 0);
      chk("full_count", 32'(load_count), DEPTH);
      chk("full_busy", 32'(busy), 0);
      vt.push_back(fv(32'h3C, 32'hA000_000F, 1'b0, 1'b0));
      vt.push_back(fv(32'h0, 32'hA000_0000, 1'b0, 1'b0));
      vt.push_back(fv(32'h1C, 32'hA000_0007, 1'b0, 1'b0));
      run_fetches();

      // Backpressure load of 6 words, older words survive
      pulse_start();
      load_seq(32'hB000_0000, 32'h11, 6, 1'b1, 1'b1);
      chk("bp_count", 32'(load_count), 6);
      chk("bp_busy", 32'(busy), 0);
      for (int i = 0; i < 6; i++) begin
         vt.push_back(fv(32'(i * 4), 32'hB000_0000 + 32'h11 * i, 1'b0, 1'b0));
      end
      vt.push_back(fv(32'h18, 32'hA000_0006, 1'b0, 1'b0));
      run_fetches();

      // load_start beats a same-cycle fetch
      fetch_req = 1'b1;
      fetch_addr = 32'h0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      fetch_req = 1'b0;
      chk("start_drop_valid", 32'(instr_valid), 0);
      chk("start_drop_busy", 32'(busy), 1);
      load_seq(32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b1);
      chk("reload_count", 32'(load_count), 1);
      vt.push_back(fv(32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0));
      vt.push_back(fv(32'h4, 32'hB000_0011, 1'b0, 1'b0));
      run_fetches();

      // Reset after 2 of 5 words
      pulse_start();
      load_seq(32'hC000_0000, 32'h1, 2, 1'b0, 1'b0);
      chk("mid_count", 32'(load_count), 2);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_count", 32'(load_count), 0);
      chk("mid_rst_ready", 32'(load_ready), 0);
      chk("mid_rst_busy", 32'(busy), 1);
      tick();
      reset = 1'b0;
      wait_clear();
      load_seq(32'h1234_5678, 32'h0, 1, 1'b0, 1'b1);
      vt.push_back(fv(32'h0, 32'h1234_5678, 1'b0, 1'b0));
      for (int i = 1; i < DEPTH; i++) begin
         vt.push_back(fv(32'(i * 4), 32'h0, 1'b0, 1'b0));
      end
      run_fetches();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
